unidad_acceso_mem: RTL and testbench
====================================

# unidad_acceso_mem

Sub-word memory access unit between the EX/MEM pipeline register and `memoria_datos`. It supports byte, halfword and word loads and stores on top of the word-only data memory. Loads extract and sign- or zero-extend the addressed lane. Sub-word stores run a two-cycle read-modify-write and stall the pipeline for one cycle. Misaligned accesses are suppressed and reported.

## Interface
Parameters:
- `ANCHO`, 32, data and address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `LeerMem_in` in 1: load request from EX/MEM.
- `EscrMem_in` in 1: store request from EX/MEM.
- `TamMem` in 2: access size. 00 = word, 01 = halfword, 10 = byte, 11 = treated as word.
- `SinSigno` in 1: zero-extend loads when 1; sign-extend when 0.
- `Direc_in` in 32: byte address.
- `Datain_in` in 32: store data, right-justified.
- `Dataout` in 32: read word from `memoria_datos`.
- `LeerMem` out 1: read enable to memory.
- `EscrMem` out 1: write enable to memory.
- `Direc` out 32: word-aligned address to memory, `{Direc_in[31:2],2'b00}`.
- `Datain` out 32: write word to memory.
- `DatoLeido` out 32: extended load result to MEM/WB.
- `Detener` out 1: stall request to the pipeline.
- `ErrorAlin` out 1: one-cycle misalignment pulse.
- `DirError` out 32: address of the last misaligned access.

## Operation
- Memory contract: `memoria_datos` returns `Dataout` combinationally while `LeerMem`=1. It writes `Datain` on the rising `clk` edge when `EscrMem`=1.
- Lanes are little-endian.
  - Byte k = bits [8k+7:8k], with k = `Direc_in[1:0]`.
  - Half 0 = [15:0], half 1 = [31:16], selected by `Direc_in[1]`.
- Alignment rules:
  - Word access is misaligned if `Direc_in[1:0]`≠0.
  - Halfword access is misaligned if `Direc_in[0]`=1.
  - Byte access is always aligned.
- Request precedence: if `LeerMem_in` and `EscrMem_in` are both 1, the store is performed and the load is ignored. `DatoLeido`=0 in that case.
- Loads (aligned): `LeerMem`=1 in the same cycle. `DatoLeido` is the extracted lane, extended per `SinSigno`, combinational from `Dataout`. No stall.
- Word store (aligned): `EscrMem`=1 and `Datain`=`Datain_in` in the same cycle. No stall.
- Sub-word store (aligned) uses the FSM:
  - `INACTIVO`: drive `LeerMem`=1 and `Detener`=1. Build the merged word combinationally: `Dataout` with the addressed lane replaced by `Datain_in[7:0]` or `[15:0]`. Capture it into `buf_escr` at the edge. Next state `RMW_ESCR`.
  - `RMW_ESCR`: drive `EscrMem`=1, `Datain`=`buf_escr`, `Detener`=0. Return to `INACTIVO` unconditionally, so the same instruction is never re-issued.
  - The pipeline holds all `*_in` inputs stable while `Detener`=1.
- Misaligned access:
  - `LeerMem`, `EscrMem` and `Detener` stay 0; memory is untouched.
  - `ErrorAlin`=1 for exactly the next cycle.
  - `DirError` is latched with `Direc_in` and holds until the next error or reset.
- Idle, with no request: `LeerMem`=`EscrMem`=0, `Datain`=0, `DatoLeido`=0.

## Timing
- Reset values: FSM=`INACTIVO`; `buf_escr`=0, `ErrorAlin`=0, `DirError`=0. All combinational outputs are 0 with no request.
- Latency:
  - Load: 0 cycles.
  - Word store: write at the end of the request cycle.
  - Sub-word store: 2 cycles; the write happens at the second edge.
- `Detener` is high for exactly one cycle per aligned sub-word store and never in `RMW_ESCR`.
- Reset asserted in `RMW_ESCR`: `EscrMem` drops asynchronously. No write occurs and the FSM returns to `INACTIVO`.
- `ErrorAlin` is registered: it asserts one edge after the faulty request and deasserts after one cycle. Back-to-back misaligned requests keep it high. `DirError` updates each time.
- Direct write-then-read of the same word on consecutive cycles is coherent, because memory writes at the edge and the read is combinational.

## Test plan
- Word store then load: store 0x12345678 at 0x460, then load word 0x460 → `EscrMem`=1 one cycle, `DatoLeido`=0x12345678, `Detener` never high.
- Byte store RMW: word 0x60 preset to 0xAABBCCDD, `sb` 0x11 at 0x62 → cycle 1 `LeerMem`=1 and `Detener`=1; cycle 2 `EscrMem`=1, `Datain`=0xAA11CCDD. A following `lw` returns 0xAA11CCDD.
- Halfword store: word 0x260 = 0x00000000, `sh` 0xBEEF at 0x262 → word becomes 0xBEEF0000.
- Load extension on word 0xAA11CCDD:
  - `lb` 0x61 → 0xFFFFFFCC.
  - `lbu` 0x61 → 0x000000CC.
  - `lh` 0x62 → 0xFFFFAA11.
  - `lhu` 0x62 → 0x0000AA11.
- Misalignment:
  - `lw` at 0x461 → no memory enables, `ErrorAlin` pulses one cycle, `DirError`=0x461.
  - `sh` at 0x263 → same behaviour, and memory is unchanged.
- Reset mid-RMW: assert `rst` during `RMW_ESCR` of `sb` 0x11 at 0x62 → `EscrMem` never asserted at the edge, word 0x60 keeps 0xAABBCCDD, and all outputs read 0.

Source files
------------

// File: rtl/unidad_acceso_mem.sv
// ---------------------------------------------------------------------------
// unidad_acceso_mem
//
// Sub-word memory access unit between the EX/MEM pipeline register and the
// word-only data memory (memoria_datos). Handles byte, halfword and word
// loads and stores. Loads extract the addressed lane and sign- or
// zero-extend it. Sub-word stores are done as a two-cycle read-modify-write:
// the unit stalls the pipeline for one cycle while it reads the old word.
// Misaligned accesses never reach memory; they are reported on ErrorAlin
// and DirError instead.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   LeerMem_in          : load request from EX/MEM
//   EscrMem_in          : store request from EX/MEM (wins over a load)
//   TamMem              : 00 word, 01 halfword, 10 byte, 11 word
//   SinSigno            : 1 = zero-extend loads, 0 = sign-extend
//   Direc_in            : byte address
//   Datain_in           : store data, right-justified
//   Dataout             : word read from memory (combinational)
//   LeerMem / EscrMem   : memory read / write enables
//   Direc               : word-aligned address to memory
//   Datain              : word written to memory
//   DatoLeido           : extended load result to MEM/WB
//   Detener             : stall request to the pipeline
//   ErrorAlin           : one-cycle misalignment pulse (registered)
//   DirError            : address of the last misaligned access
// ---------------------------------------------------------------------------
module unidad_acceso_mem #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LeerMem_in,
    input  logic             EscrMem_in,
    input  logic [1:0]       TamMem,
    input  logic             SinSigno,
    input  logic [ANCHO-1:0] Direc_in,
    input  logic [ANCHO-1:0] Datain_in,
    input  logic [ANCHO-1:0] Dataout,
    output logic             LeerMem,
    output logic             EscrMem,
    output logic [ANCHO-1:0] Direc,
    output logic [ANCHO-1:0] Datain,
    output logic [ANCHO-1:0] DatoLeido,
    output logic             Detener,
    output logic             ErrorAlin,
    output logic [ANCHO-1:0] DirError
);

    typedef enum logic {
        INACTIVO = 1'b0,
        RMW_ESCR = 1'b1
    } estado_t;

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [ANCHO-1:0] r_buf_escr;
    logic             r_error_alin;
    logic [ANCHO-1:0] r_dir_error;

    // ------------------------------------------------------------------
    // Request decode. Requests are masked while rst is high so that every
    // enable reads 0 during reset, even if the pipeline still presents one.
    // ------------------------------------------------------------------
    logic w_es_byte, w_es_media, w_es_palabra;
    logic w_escr, w_carga, w_desalin;
    logic w_escr_palabra, w_escr_sub, w_carga_valida;

    assign w_es_byte    = (TamMem == 2'b10);
    assign w_es_media   = (TamMem == 2'b01);
    assign w_es_palabra = ~w_es_byte & ~w_es_media;   // 00 and 11

    assign w_escr  = EscrMem_in & ~rst;
    assign w_carga = LeerMem_in & ~EscrMem_in & ~rst; // store has precedence

    assign w_desalin = (w_es_palabra & (Direc_in[1:0] != 2'b00))
                     | (w_es_media   &  Direc_in[0]);

    assign w_escr_palabra = w_escr  & ~w_desalin &  w_es_palabra;
    assign w_escr_sub     = w_escr  & ~w_desalin & ~w_es_palabra;
    assign w_carga_valida = w_carga & ~w_desalin;

    // ------------------------------------------------------------------
    // Lane position: bit offset of the addressed byte/halfword (little-endian).
    // ------------------------------------------------------------------
    logic [4:0] w_desp;

    always_comb begin
        // NOTE: every signal driven in always_comb gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        w_desp = 5'd0;
        if (w_es_byte)
            w_desp = {Direc_in[1:0], 3'b000};
        else if (w_es_media)
            w_desp = {Direc_in[1], 4'b0000};
    end

    // Load path: shift the addressed lane down to bit 0 and extend it.
    logic [ANCHO-1:0] w_carril;
    logic [ANCHO-1:0] w_dato_ext;

    assign w_carril = Dataout >> w_desp;

    always_comb begin
        w_dato_ext = Dataout;
        if (w_es_byte)
            w_dato_ext = {{(ANCHO-8){~SinSigno & w_carril[7]}}, w_carril[7:0]};
        else if (w_es_media)
            w_dato_ext = {{(ANCHO-16){~SinSigno & w_carril[15]}}, w_carril[15:0]};
    end

    // Store merge: old word with the addressed lane replaced by new data.
    logic [ANCHO-1:0] w_mascara;
    logic [ANCHO-1:0] w_dato_desp;
    logic [ANCHO-1:0] w_palabra_fusion;

    assign w_mascara   = w_es_byte ? (ANCHO'(8'hFF) << w_desp)
                                   : (ANCHO'(16'hFFFF) << w_desp);
    assign w_dato_desp = w_es_byte ? (ANCHO'(Datain_in[7:0])  << w_desp)
                                   : (ANCHO'(Datain_in[15:0]) << w_desp);
    assign w_palabra_fusion = (Dataout & ~w_mascara) | (w_dato_desp & w_mascara);

    // ------------------------------------------------------------------
    // FSM: next state and memory-side outputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_estado_sig = r_estado;
        LeerMem      = 1'b0;
        EscrMem      = 1'b0;
        Detener      = 1'b0;
        Datain       = '0;
        DatoLeido    = '0;
        case (r_estado)
            INACTIVO: begin
                if (w_carga_valida) begin
                    LeerMem   = 1'b1;
                    DatoLeido = w_dato_ext;
                end else if (w_escr_palabra) begin
                    EscrMem = 1'b1;
                    Datain  = Datain_in;
                end else if (w_escr_sub) begin
                    // Read phase: the merged word is captured at this edge.
                    LeerMem      = 1'b1;
                    Detener      = 1'b1;
                    w_estado_sig = RMW_ESCR;
                end
            end
            RMW_ESCR: begin
                // Write phase. Inputs are ignored and the state always
                // returns to INACTIVO so the store is never re-issued.
                EscrMem      = 1'b1;
                Datain       = r_buf_escr;
                w_estado_sig = INACTIVO;
            end
            default: w_estado_sig = INACTIVO;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_estado <= INACTIVO;
        else
            r_estado <= w_estado_sig;
    end

    // NOTE: r_buf_escr is an ordinary register, not a memory array, so it is
    // reset; the data memory itself lives outside and is never reset here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_buf_escr <= '0;
        else if (r_estado == INACTIVO && w_escr_sub)
            r_buf_escr <= w_palabra_fusion;
    end

    // Misalignment report: pulse is high for each cycle that follows a
    // misaligned request, so back-to-back errors keep it asserted.
    logic w_error_ahora;
    assign w_error_ahora = (r_estado == INACTIVO) & (w_escr | w_carga) & w_desalin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error_alin <= 1'b0;
            r_dir_error  <= '0;
        end else begin
            r_error_alin <= w_error_ahora;
            if (w_error_ahora)
                r_dir_error <= Direc_in;
        end
    end

    assign Direc     = {Direc_in[ANCHO-1:2], 2'b00};
    assign ErrorAlin = r_error_alin;
    assign DirError  = r_dir_error;

endmodule

// File: tb/tb_unidad_acceso_mem.sv
// ---------------------------------------------------------------------------
// tb_unidad_acceso_mem
//
// Directed bench for unidad_acceso_mem with a small behavioural model of
// memoria_datos (combinational read while LeerMem, write on the rising edge
// while EscrMem). Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_unidad_acceso_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        LeerMem_in, EscrMem_in, SinSigno;
    logic [1:0]  TamMem;
    logic [31:0] Direc_in, Datain_in, Dataout;
    logic        LeerMem, EscrMem, Detener, ErrorAlin;
    logic [31:0] Direc, Datain, DatoLeido, DirError;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    unidad_acceso_mem #(.ANCHO(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .LeerMem_in (LeerMem_in),
        .EscrMem_in (EscrMem_in),
        .TamMem     (TamMem),
        .SinSigno   (SinSigno),
        .Direc_in   (Direc_in),
        .Datain_in  (Datain_in),
        .Dataout    (Dataout),
        .LeerMem    (LeerMem),
        .EscrMem    (EscrMem),
        .Direc      (Direc),
        .Datain     (Datain),
        .DatoLeido  (DatoLeido),
        .Detener    (Detener),
        .ErrorAlin  (ErrorAlin),
        .DirError   (DirError)
    );

    // memoria_datos model: 1024 words, word index = Direc[11:2].
    logic [31:0] mem [0:1023];

    always_comb Dataout = LeerMem ? mem[Direc[11:2]] : 32'h0;

    always @(posedge clk)
        if (EscrMem) mem[Direc[11:2]] <= Datain;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Present a request just after the falling edge and let it settle.
    task automatic req(input logic rd, input logic wr, input logic [1:0] tam,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        LeerMem_in = rd;
        EscrMem_in = wr;
        TamMem     = tam;
        SinSigno   = uns;
        Direc_in   = a;
        Datain_in  = d;
        #1;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h60 >> 2] = 32'hAABBCCDD;

        rst = 1'b1;
        LeerMem_in = 1'b0; EscrMem_in = 1'b0; TamMem = 2'b00; SinSigno = 1'b0;
        Direc_in = 32'h0; Datain_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst LeerMem",   {31'b0, LeerMem},   32'h0);
        check("rst EscrMem",   {31'b0, EscrMem},   32'h0);
        check("rst Detener",   {31'b0, Detener},   32'h0);
        check("rst ErrorAlin", {31'b0, ErrorAlin}, 32'h0);
        check("rst DirError",  DirError,           32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---- Word store then load at 0x460 ----
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h460, 32'h12345678);
        check("sw EscrMem", {31'b0, EscrMem}, 32'h1);
        check("sw LeerMem", {31'b0, LeerMem}, 32'h0);
        check("sw Detener", {31'b0, Detener}, 32'h0);
        check("sw Datain",  Datain,           32'h12345678);
        check("sw Direc",   Direc,            32'h460);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h460, 32'h0);
        check("lw LeerMem",   {31'b0, LeerMem}, 32'h1);
        check("lw DatoLeido", DatoLeido,        32'h12345678);
        check("lw Detener",   {31'b0, Detener}, 32'h0);

        // ---- Byte store RMW: sb 0x11 at 0x62 over 0xAABBCCDD ----
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h62, 32'h12345611);
        check("sb c1 LeerMem", {31'b0, LeerMem}, 32'h1);
        check("sb c1 Detener", {31'b0, Detener}, 32'h1);
        check("sb c1 EscrMem", {31'b0, EscrMem}, 32'h0);
        check("sb c1 Direc",   Direc,            32'h60);
        @(negedge clk); #1;   // inputs held by the stalled pipeline
        check("sb c2 EscrMem", {31'b0, EscrMem}, 32'h1);
        check("sb c2 Detener", {31'b0, Detener}, 32'h0);
        check("sb c2 LeerMem", {31'b0, LeerMem}, 32'h0);
        check("sb c2 Datain",  Datain,           32'hAA11CCDD);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h60, 32'h0);
        check("sb readback", DatoLeido, 32'hAA11CCDD);

        // ---- Load extension on 0xAA11CCDD ----
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h61, 32'h0);
        check("lb 0x61",  DatoLeido, 32'hFFFFFFCC);
        req(1'b1, 1'b0, 2'b10, 1'b1, 32'h61, 32'h0);
        check("lbu 0x61", DatoLeido, 32'h000000CC);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h62, 32'h0);
        check("lh 0x62",  DatoLeido, 32'hFFFFAA11);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h62, 32'h0);
        check("lhu 0x62", DatoLeido, 32'h0000AA11);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h63, 32'h0);
        check("lb 0x63",  DatoLeido, 32'hFFFFFFAA);
        req(1'b1, 1'b0, 2'b10, 1'b1, 32'h60, 32'h0);
        check("lbu 0x60", DatoLeido, 32'h000000DD);

        // ---- Halfword store: sh 0xBEEF at 0x262 over 0 ----
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h262, 32'h0000BEEF);
        check("sh c1 Detener", {31'b0, Detener}, 32'h1);
        @(negedge clk); #1;
        check("sh c2 Datain",  Datain,           32'hBEEF0000);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h260, 32'h0);
        check("sh readback", DatoLeido, 32'hBEEF0000);

        // ---- Idle outputs ----
        idle();
        check("idle Datain",    Datain,           32'h0);
        check("idle DatoLeido", DatoLeido,        32'h0);
        check("idle LeerMem",   {31'b0, LeerMem}, 32'h0);

        // ---- Misaligned lw at 0x461 ----
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h461, 32'h0);
        check("mis lw LeerMem",   {31'b0, LeerMem},   32'h0);
        check("mis lw EscrMem",   {31'b0, EscrMem},   32'h0);
        check("mis lw DatoLeido", DatoLeido,          32'h0);
        check("mis lw pre Err",   {31'b0, ErrorAlin}, 32'h0);
        idle();
        check("mis lw ErrorAlin", {31'b0, ErrorAlin}, 32'h1);
        check("mis lw DirError",  DirError,           32'h461);
        idle();
        check("mis lw Err drop",  {31'b0, ErrorAlin}, 32'h0);
        check("mis lw DirHold",   DirError,           32'h461);

        // ---- Misaligned sh at 0x263, then lw at 0x465 back-to-back ----
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h263, 32'h00001234);
        check("mis sh EscrMem", {31'b0, EscrMem}, 32'h0);
        check("mis sh LeerMem", {31'b0, LeerMem}, 32'h0);
        check("mis sh Detener", {31'b0, Detener}, 32'h0);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h465, 32'h0);
        check("b2b Err 1",      {31'b0, ErrorAlin}, 32'h1);
        check("b2b DirError 1", DirError,           32'h263);
        idle();
        check("b2b Err 2",      {31'b0, ErrorAlin}, 32'h1);
        check("b2b DirError 2", DirError,           32'h465);
        idle();
        check("b2b Err drop",   {31'b0, ErrorAlin}, 32'h0);
        check("mis sh mem",     mem[32'h260 >> 2],  32'hBEEF0000);

        // ---- Load and store together: store wins ----
        req(1'b1, 1'b1, 2'b00, 1'b0, 32'h300, 32'hCAFEF00D);
        check("ld+st EscrMem",   {31'b0, EscrMem}, 32'h1);
        check("ld+st LeerMem",   {31'b0, LeerMem}, 32'h0);
        check("ld+st DatoLeido", DatoLeido,        32'h0);
        idle();
        check("ld+st mem", mem[32'h300 >> 2], 32'hCAFEF00D);

        // ---- Reset during RMW_ESCR of sb 0x11 at 0x62 ----
        mem[32'h60 >> 2] = 32'hAABBCCDD;
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h62, 32'h00000011);
        check("rmw rst c1 Detener", {31'b0, Detener}, 32'h1);
        @(negedge clk); #1;
        check("rmw rst c2 EscrMem", {31'b0, EscrMem}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rmw rst EscrMem drop", {31'b0, EscrMem}, 32'h0);
        LeerMem_in = 1'b0; EscrMem_in = 1'b0; Direc_in = 32'h0; Datain_in = 32'h0;
        @(posedge clk); #1;
        check("rmw rst mem kept",  mem[32'h60 >> 2],   32'hAABBCCDD);
        check("rmw rst LeerMem",   {31'b0, LeerMem},   32'h0);
        check("rmw rst EscrMem",   {31'b0, EscrMem},   32'h0);
        check("rmw rst Detener",   {31'b0, Detener},   32'h0);
        check("rmw rst Datain",    Datain,             32'h0);
        check("rmw rst DatoLeido", DatoLeido,          32'h0);
        check("rmw rst ErrorAlin", {31'b0, ErrorAlin}, 32'h0);
        check("rmw rst DirError",  DirError,           32'h0);
        @(negedge clk);
        rst = 1'b0;
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h60, 32'h0);
        check("post rst lw",      DatoLeido,        32'hAABBCCDD);
        check("post rst Detener", {31'b0, Detener}, 32'h0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
